// File: rtl/solver_pkg.sv
// Shared constants, state type and frame-length helper for the Solver input packer.
package solver_pkg;

  localparam int unsigned CHAR_W    = 6;
  localparam int unsigned RAW_CHARS = 10;
  localparam int unsigned ENC_CHARS = 13;
  localparam int unsigned RAW_W     = CHAR_W * RAW_CHARS;
  localparam int unsigned ENC_W     = CHAR_W * ENC_CHARS;
  localparam int unsigned CNT_W     = 16;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // Characters per frame for the given mode.
  function automatic logic [3:0] frame_chars(input logic mode);
    return (mode == MODE_ENC) ? 4'(RAW_CHARS) : 4'(ENC_CHARS);
  endfunction

endpackage

// File: rtl/solver_frame_packer_char_counter.sv
// Character counter for one frame: load to 1 on SOF, increment on each further char,
// flags when the next increment completes the frame for the current mode.
module frame_char_counter
  import solver_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic inc,
  input  logic mode,
  output logic last
);

  logic [3:0] cnt_q, cnt_d;

  // Next count: SOF restarts at one, otherwise count accepted chars.
  always_comb begin
    cnt_d = cnt_q;
    if (load)     cnt_d = 4'd1;
    else if (inc) cnt_d = cnt_q + 4'd1;
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign last = (cnt_q == (frame_chars(mode) - 4'd1));

endmodule

// File: rtl/solver_frame_packer.sv
// Packs 6-bit characters into 60-bit raw or 78-bit encrypted Solver words and holds
// each finished word under a valid/ready handshake.
module solver_frame_packer
  import solver_pkg::*;
(
  input  logic               Clk,
  input  logic               Rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CHAR_W-1:0]  in_char,
  input  logic               in_sof,
  input  logic               in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_mode,
  output logic [RAW_W-1:0]   raw_data,
  output logic [ENC_W-1:0]   enc_data,
  output logic               frame_err,
  output logic [CNT_W-1:0]   frame_count
);

  state_t             state_q, state_d;
  logic [ENC_W-1:0]   shreg_q, shreg_d;
  logic               out_valid_q, out_valid_d;
  logic               mode_q, mode_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   fcnt_q, fcnt_d;
  logic               cnt_load, cnt_inc, cnt_last;
  logic               beat, handoff;

  assign in_ready = (state_q != ST_HOLD);
  assign beat     = in_valid & in_ready;
  assign handoff  = out_valid_q & out_ready;

  frame_char_counter u_cnt (
    .clk  (Clk),
    .rst  (Rst),
    .load (cnt_load),
    .inc  (cnt_inc),
    .mode (mode_q),
    .last (cnt_last)
  );

  // Next-state, packing and handshake logic.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    out_valid_d = out_valid_q;
    mode_d      = mode_q;
    err_d       = 1'b0;
    fcnt_d      = fcnt_q;
    cnt_load    = 1'b0;
    cnt_inc     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (beat) begin
          if (in_sof) begin
            mode_d   = in_mode;
            shreg_d  = {{(ENC_W-CHAR_W){1'b0}}, in_char};
            cnt_load = 1'b1;
            state_d  = ST_FILL;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_FILL: begin
        if (beat) begin
          if (in_sof) begin
            // Mid-frame SOF: abandon the partial word and restart on this char.
            mode_d   = in_mode;
            shreg_d  = {{(ENC_W-CHAR_W){1'b0}}, in_char};
            cnt_load = 1'b1;
            err_d    = 1'b1;
          end else begin
            shreg_d = {shreg_q[ENC_W-CHAR_W-1:0], in_char};
            cnt_inc = 1'b1;
            if (cnt_last) begin
              state_d     = ST_HOLD;
              out_valid_d = 1'b1;
            end
          end
        end
      end
      ST_HOLD: begin
        if (handoff) begin
          out_valid_d = 1'b0;
          fcnt_d      = fcnt_q + CNT_W'(1);
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= ST_IDLE;
      shreg_q     <= '0;
      out_valid_q <= 1'b0;
      mode_q      <= MODE_ENC;
      err_q       <= 1'b0;
      fcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      out_valid_q <= out_valid_d;
      mode_q      <= mode_d;
      err_q       <= err_d;
      fcnt_q      <= fcnt_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_mode    = mode_q;
  assign raw_data    = shreg_q[RAW_W-1:0];
  assign enc_data    = shreg_q;
  assign frame_err   = err_q;
  assign frame_count = fcnt_q;

endmodule

// File: tb/tb_solver_frame_packer.sv
// Directed bench for solver_frame_packer with a per-cycle handshake/counter monitor.
module tb_solver_frame_packer;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  in_char = '0;
  logic        in_sof = 1'b0;
  logic        in_mode = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_mode;
  logic [59:0] raw_data;
  logic [77:0] enc_data;
  logic        frame_err;
  logic [15:0] frame_count;

  solver_frame_packer dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_char     (in_char),
    .in_sof      (in_sof),
    .in_mode     (in_mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_mode    (out_mode),
    .raw_data    (raw_data),
    .enc_data    (enc_data),
    .frame_err   (frame_err),
    .frame_count (frame_count)
  );

  always #5 Clk = ~Clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic chk(input string tag, input logic [77:0] got, input logic [77:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic send(input logic [5:0] c, input logic sof, input logic mode);
    in_valid = 1'b1;
    in_char  = c;
    in_sof   = sof;
    in_mode  = mode;
    tick();
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  // Monitor: inputs seen at a falling edge are those applied at the next rising edge.
  logic        armed = 1'b0;
  logic        p_rst, p_ov, p_ordy, p_mode;
  logic [77:0] p_word;
  logic [15:0] p_fc;
  logic [15:0] exp_fc;

  always @(negedge Clk) begin
    if (armed) begin
      if (out_valid) chk("no_beat_in_hold", {77'b0, in_ready}, 78'd0);
      if (!p_rst && p_ov && !p_ordy) begin
        chk("word_stable", enc_data, p_word);
        chk("mode_stable", {77'b0, out_mode}, {77'b0, p_mode});
        chk("valid_held", {77'b0, out_valid}, 78'd1);
      end
      exp_fc = p_rst ? 16'd0 : (p_fc + {15'b0, (p_ov & p_ordy)});
      chk("fc_model", {62'b0, frame_count}, {62'b0, exp_fc});
    end
    armed  <= 1'b1;
    p_rst  <= Rst;
    p_ov   <= out_valid;
    p_ordy <= out_ready;
    p_mode <= out_mode;
    p_word <= enc_data;
    p_fc   <= frame_count;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  localparam logic [59:0] RAW1 = {6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9, 6'd10};
  localparam logic [59:0] RAW2 = {6'd40, 6'd41, 6'd42, 6'd43, 6'd44, 6'd45, 6'd46, 6'd47, 6'd48, 6'd49};
  localparam logic [77:0] ENC1 = 78'h3FFF_FFFF_FFFF_FFFF_FFFF;
  localparam logic [77:0] ENC3 = {6'd5, 6'd6, 6'd7, 6'd8, 6'd9, 6'd10, 6'd11,
                                  6'd12, 6'd13, 6'd14, 6'd15, 6'd16, 6'd17};

  initial begin
    // Reset state
    repeat (3) tick();
    Rst = 1'b0;
    chk("rst_in_ready",  {77'b0, in_ready},  78'd1);
    chk("rst_out_valid", {77'b0, out_valid}, 78'd0);
    chk("rst_out_mode",  {77'b0, out_mode},  78'd0);
    chk("rst_err",       {77'b0, frame_err}, 78'd0);
    chk("rst_fc",        {62'b0, frame_count}, 78'd0);
    chk("rst_word",      enc_data, 78'd0);

    // Raw frame, chars 1..10, downstream always ready
    out_ready = 1'b1;
    for (int i = 1; i <= 10; i++) send(6'(i), (i == 1), 1'b0);
    chk("raw_valid", {77'b0, out_valid}, 78'd1);
    chk("raw_data",  {18'b0, raw_data}, {18'b0, RAW1});
    chk("raw_mode",  {77'b0, out_mode}, 78'd0);
    chk("raw_busy",  {77'b0, in_ready}, 78'd0);
    tick();
    chk("raw_done_valid", {77'b0, out_valid}, 78'd0);
    chk("raw_fc",    {62'b0, frame_count}, 78'd1);
    chk("raw_ready", {77'b0, in_ready}, 78'd1);

    // Encrypted frame, 13 x 3F
    for (int i = 0; i < 13; i++) send(6'h3F, (i == 0), 1'b1);
    chk("enc_valid", {77'b0, out_valid}, 78'd1);
    chk("enc_data",  enc_data, ENC1);
    chk("enc_mode",  {77'b0, out_mode}, 78'd1);
    tick();
    chk("enc_fc", {62'b0, frame_count}, 78'd2);

    // Backpressure for 20 cycles
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) send(6'(40 + i), (i == 0), 1'b0);
    repeat (20) tick();
    chk("bp_valid", {77'b0, out_valid}, 78'd1);
    chk("bp_data",  {18'b0, raw_data}, {18'b0, RAW2});
    chk("bp_in_ready", {77'b0, in_ready}, 78'd0);
    chk("bp_fc",    {62'b0, frame_count}, 78'd2);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_release_valid", {77'b0, out_valid}, 78'd0);
    chk("bp_release_fc", {62'b0, frame_count}, 78'd3);
    repeat (2) tick();
    chk("bp_single_handoff", {62'b0, frame_count}, 78'd3);

    // SOF after four chars restarts the frame in mode 1
    out_ready = 1'b1;
    send(6'h0A, 1'b1, 1'b0);
    send(6'h0B, 1'b0, 1'b0);
    send(6'h0C, 1'b0, 1'b0);
    send(6'h0D, 1'b0, 1'b0);
    chk("restart_no_err_yet", {77'b0, frame_err}, 78'd0);
    send(6'h05, 1'b1, 1'b1);
    chk("restart_err", {77'b0, frame_err}, 78'd1);
    for (int i = 6; i <= 17; i++) begin
      send(6'(i), 1'b0, 1'b0);
      if (i == 6) chk("restart_err_pulse", {77'b0, frame_err}, 78'd0);
    end
    chk("restart_valid", {77'b0, out_valid}, 78'd1);
    chk("restart_data",  enc_data, ENC3);
    chk("restart_mode",  {77'b0, out_mode}, 78'd1);
    tick();
    chk("restart_fc", {62'b0, frame_count}, 78'd4);

    // Stray non-SOF char in IDLE
    send(6'h2A, 1'b0, 1'b0);
    chk("stray_err",   {77'b0, frame_err}, 78'd1);
    chk("stray_ready", {77'b0, in_ready}, 78'd1);
    chk("stray_valid", {77'b0, out_valid}, 78'd0);
    chk("stray_word",  enc_data, ENC3);
    tick();
    chk("stray_err_pulse", {77'b0, frame_err}, 78'd0);
    chk("stray_fc", {62'b0, frame_count}, 78'd4);

    // Reset on the 7th char of a raw frame
    for (int i = 1; i <= 6; i++) send(6'(i), (i == 1), 1'b0);
    in_valid = 1'b1;
    in_char  = 6'd7;
    Rst      = 1'b1;
    tick();
    in_valid = 1'b0;
    Rst      = 1'b0;
    chk("midrst_valid", {77'b0, out_valid}, 78'd0);
    chk("midrst_fc",    {62'b0, frame_count}, 78'd0);
    chk("midrst_word",  enc_data, 78'd0);
    chk("midrst_mode",  {77'b0, out_mode}, 78'd0);
    chk("midrst_err",   {77'b0, frame_err}, 78'd0);
    chk("midrst_ready", {77'b0, in_ready}, 78'd1);
    for (int i = 1; i <= 10; i++) send(6'(i), (i == 1), 1'b0);
    chk("fresh_valid", {77'b0, out_valid}, 78'd1);
    chk("fresh_data",  {18'b0, raw_data}, {18'b0, RAW1});
    tick();
    chk("fresh_fc", {62'b0, frame_count}, 78'd1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
